// File: rtl/fft_out_reorder.sv
// Reorders the FFT core's bit-reversed, interleaved re/im word stream into
// natural bin order through a two-bank ping-pong buffer with a valid/ready output.
module fft_out_reorder #(
    parameter int DW   = 17,
    parameter int LOGN = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [DW-1:0]   data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [DW-1:0]   re_o,
    output logic [DW-1:0]   im_o,
    output logic [LOGN-1:0] bin_o,
    output logic            last_o,
    output logic            overflow_o
);

    localparam int N = 1 << LOGN;

    localparam logic [1:0] BK_FREE  = 2'd0;
    localparam logic [1:0] BK_FILL  = 2'd1;
    localparam logic [1:0] BK_FULL  = 2'd2;
    localparam logic [1:0] BK_DRAIN = 2'd3;

    localparam logic [0:0] RD_IDLE  = 1'b0;
    localparam logic [0:0] RD_DRAIN = 1'b1;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = {LOGN{1'b0}};
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    // Write and read sides only ever move a bank out of states the other side never touches.
    function automatic logic [1:0] bank_next(input logic [1:0] cur,
                                             input logic       start,
                                             input logic       done,
                                             input logic       claim,
                                             input logic       rel);
        logic [1:0] nxt;
        if (done) begin
            nxt = BK_FULL;
        end else if (start) begin
            nxt = BK_FILL;
        end else if (claim) begin
            nxt = BK_DRAIN;
        end else if (rel) begin
            nxt = BK_FREE;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [LOGN:0]   wc_q, wc_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic            drop_q, drop_d;
    logic            ovf_q, ovf_d;
    logic [1:0]      bank0_q, bank0_d;
    logic [1:0]      bank1_q, bank1_d;
    logic [0:0]      rd_st_q, rd_st_d;
    logic [LOGN:0]   ra_q, ra_d;

    logic            valid_q;
    logic [DW-1:0]   re_q, im_q;
    logic [LOGN-1:0] bin_q;
    logic            last_q;

    logic [DW-1:0]   mem_re [0:2*N-1];
    logic [DW-1:0]   mem_im [0:2*N-1];

    logic            wr_en_s, wr_start_s, wr_done_s;
    logic            load_s, xfer_s, claim_s, claim_bank_s, rel_s;
    logic [1:0]      wbank_st_s, rbank_st_s, obank_st_s;
    logic [LOGN:0]   waddr_s, raddr_s;

    assign wbank_st_s = wbank_q ? bank1_q : bank0_q;
    assign rbank_st_s = rbank_q ? bank1_q : bank0_q;
    assign obank_st_s = rbank_q ? bank0_q : bank1_q;
    assign waddr_s    = {wbank_q, bitrev(wc_q[LOGN:1])};
    assign raddr_s    = {rbank_q, ra_q[LOGN-1:0]};
    assign xfer_s     = valid_q & ready_i;

    // Input framing: word counter, frame admit/drop decision and fill completion.
    always_comb begin
        wc_d       = wc_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        wbank_d    = wbank_q;
        wr_en_s    = 1'b0;
        wr_start_s = 1'b0;
        wr_done_s  = 1'b0;
        if (valid_i) begin
            wc_d = wc_q + {{LOGN{1'b0}}, 1'b1};
            if (wc_q == {(LOGN+1){1'b0}}) begin
                if (wbank_st_s == BK_FREE) begin
                    wr_en_s    = 1'b1;
                    wr_start_s = 1'b1;
                    drop_d     = 1'b0;
                end else begin
                    drop_d = 1'b1;
                    ovf_d  = 1'b1;
                end
            end else if (!drop_q) begin
                wr_en_s   = 1'b1;
                wr_done_s = (wc_q == {(LOGN+1){1'b1}});
            end else begin
                wr_en_s = 1'b0;
            end
            if (wr_done_s) begin
                wbank_d = ~wbank_q;
            end else begin
                wbank_d = wbank_q;
            end
        end else begin
            wc_d = wc_q;
        end
    end

    // Read FSM: claims a full bank, streams it out in address order, releases it after bin N-1.
    always_comb begin
        rd_st_d      = rd_st_q;
        ra_d         = ra_q;
        rbank_d      = rbank_q;
        load_s       = 1'b0;
        claim_s      = 1'b0;
        claim_bank_s = rbank_q;
        rel_s        = 1'b0;
        case (rd_st_q)
            RD_IDLE: begin
                if (rbank_st_s == BK_FULL) begin
                    rd_st_d      = RD_DRAIN;
                    ra_d         = {(LOGN+1){1'b0}};
                    claim_s      = 1'b1;
                    claim_bank_s = rbank_q;
                end else begin
                    rd_st_d = RD_IDLE;
                end
            end
            RD_DRAIN: begin
                if (!ra_q[LOGN] && (!valid_q || ready_i)) begin
                    load_s = 1'b1;
                    ra_d   = ra_q + {{LOGN{1'b0}}, 1'b1};
                end else begin
                    ra_d = ra_q;
                end
                if (xfer_s && last_q) begin
                    rel_s   = 1'b1;
                    rbank_d = ~rbank_q;
                    if (obank_st_s == BK_FULL) begin
                        rd_st_d      = RD_DRAIN;
                        ra_d         = {(LOGN+1){1'b0}};
                        claim_s      = 1'b1;
                        claim_bank_s = ~rbank_q;
                    end else begin
                        rd_st_d = RD_IDLE;
                    end
                end else begin
                    rd_st_d = RD_DRAIN;
                end
            end
            default: begin
                rd_st_d = RD_IDLE;
            end
        endcase
    end

    // Per-bank ownership state.
    always_comb begin
        bank0_d = bank_next(bank0_q, wr_start_s & ~wbank_q, wr_done_s & ~wbank_q,
                            claim_s & ~claim_bank_s, rel_s & ~rbank_q);
        bank1_d = bank_next(bank1_q, wr_start_s & wbank_q, wr_done_s & wbank_q,
                            claim_s & claim_bank_s, rel_s & rbank_q);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q    <= {(LOGN+1){1'b0}};
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            drop_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bank0_q <= BK_FREE;
            bank1_q <= BK_FREE;
            rd_st_q <= RD_IDLE;
            ra_q    <= {(LOGN+1){1'b0}};
        end else begin
            wc_q    <= wc_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            bank0_q <= bank0_d;
            bank1_q <= bank1_d;
            rd_st_q <= rd_st_d;
            ra_q    <= ra_d;
        end
    end

    // Output register stage; the buffer read lands directly here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            re_q    <= {DW{1'b0}};
            im_q    <= {DW{1'b0}};
            bin_q   <= {LOGN{1'b0}};
            last_q  <= 1'b0;
        end else if (load_s) begin
            valid_q <= 1'b1;
            re_q    <= mem_re[raddr_s];
            im_q    <= mem_im[raddr_s];
            bin_q   <= ra_q[LOGN-1:0];
            last_q  <= (ra_q[LOGN-1:0] == {LOGN{1'b1}});
        end else if (xfer_s) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Buffer storage; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            if (wc_q[0]) begin
                mem_im[waddr_s] <= data_i;
            end else begin
                mem_re[waddr_s] <= data_i;
            end
        end
    end

    assign valid_o    = valid_q;
    assign re_o       = re_q;
    assign im_o       = im_q;
    assign bin_o      = bin_q;
    assign last_o     = last_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder with a frame-level reference model and scoreboard.
module tb_fft_out_reorder;

    localparam int DW   = 17;
    localparam int LOGN = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_i;
    logic [DW-1:0]   data_i;
    logic            ready_i;
    logic            valid_o;
    logic [DW-1:0]   re_o, im_o;
    logic [LOGN-1:0] bin_o;
    logic            last_o;
    logic            overflow_o;

    fft_out_reorder #(.DW(DW), .LOGN(LOGN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .re_o       (re_o),
        .im_o       (im_o),
        .bin_o      (bin_o),
        .last_o     (last_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_bins = 0;
    int occ = 0;
    bit exp_ovf = 1'b0;
    bit rand_ready = 1'b0;

    logic [DW-1:0] exp_re[$];
    logic [DW-1:0] exp_im[$];
    int            exp_bin[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int brev5(input int n);
        int r = 0;
        for (int i = 0; i < 5; i++) r = (r << 1) | ((n >> i) & 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    bit              stall_q = 1'b0;
    logic [DW-1:0]   h_re, h_im;
    logic [LOGN-1:0] h_bin;
    logic            h_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                check("hold", {valid_o, last_o, bin_o, re_o, im_o},
                      {1'b1, h_last, h_bin, h_re, h_im});
            if (valid_o && ready_i) begin
                if (exp_re.size() == 0) begin
                    check("extra_bin", {63'd0, valid_o}, 64'd0);
                end else begin
                    int eb;
                    eb = exp_bin.pop_front();
                    check("re", re_o, exp_re.pop_front());
                    check("im", im_o, exp_im.pop_front());
                    check("bin", bin_o, eb);
                    check("last", last_o, (eb == 31));
                    if (eb == 31) occ--;
                end
                n_bins++;
            end
            stall_q = valid_o && !ready_i;
            h_re = re_o; h_im = im_o; h_bin = bin_o; h_last = last_o;
        end
    end

    // One 64-word frame; the model admits it only if fewer than two frames are held.
    task automatic send_frame(input int base, input bit rnd_data, input bit gaps);
        logic [DW-1:0] w [64];
        bit acc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_i = 1'b0;
                    tick();
                end
            end
            w[i] = rnd_data ? DW'($urandom) : DW'(base + i);
            valid_i = 1'b1;
            data_i  = w[i];
            if (i == 0) begin
                acc = (occ < 2);
                if (acc) occ++;
                else exp_ovf = 1'b1;
            end
            tick();
            if (i == 0) check("ovf_w0", overflow_o, exp_ovf);
        end
        valid_i = 1'b0;
        if (acc) begin
            for (int k = 0; k < 32; k++) begin
                int n = brev5(k);
                exp_re.push_back(w[2*n]);
                exp_im.push_back(w[2*n+1]);
                exp_bin.push_back(k);
            end
        end
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 3000 && exp_re.size() > 0; i++) tick();
        check("drain_left", exp_re.size(), 0);
        tick();
    endtask

    task automatic ramp_with_latency();
        send_frame(0, 1'b0, 1'b0);
        check("lat_t0", valid_o, 1'b0);
        tick();
        check("lat_t1", valid_o, 1'b0);
        tick();
        check("lat_t2", valid_o, 1'b1);
        check("lat_bin0", bin_o, 0);
    endtask

    int n0;

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b1;
        repeat (3) tick();
        check("rst_valid", valid_o, 1'b0);
        check("rst_re", re_o, 0);
        check("rst_im", im_o, 0);
        check("rst_bin", bin_o, 0);
        check("rst_last", last_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Ramp frame with first-bin latency.
        ramp_with_latency();
        wait_drained();

        // Back-to-back frames.
        n0 = n_bins;
        send_frame(0, 1'b0, 1'b0);
        send_frame(100, 1'b0, 1'b0);
        wait_drained();
        check("b2b_bins", n_bins - n0, 64);
        check("b2b_ovf", overflow_o, exp_ovf);

        // Gapped input.
        send_frame(0, 1'b0, 1'b1);
        wait_drained();

        // Random data with random output stalls.
        rand_ready = 1'b1;
        send_frame(0, 1'b1, 1'b0);
        send_frame(0, 1'b1, 1'b1);
        wait_drained();
        rand_ready = 1'b0;
        ready_i = 1'b1;

        // Backpressure overflow: A and B held, C dropped.
        ready_i = 1'b0;
        n0 = n_bins;
        send_frame(300, 1'b1, 1'b0);
        send_frame(400, 1'b0, 1'b0);
        send_frame(500, 1'b0, 1'b0);
        repeat (5) tick();
        check("ovf_sticky", overflow_o, 1'b1);
        ready_i = 1'b1;
        wait_drained();
        repeat (40) tick();
        check("ovf_bins", n_bins - n0, 64);
        check("ovf_after", overflow_o, 1'b1);

        // Reset in the middle of a drain.
        send_frame(0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (valid_o && bin_o == 5'd10) break;
            tick();
        end
        check("rst_at_bin10", {63'd0, valid_o && bin_o == 5'd10}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out", {valid_o, last_o, bin_o, re_o, im_o, overflow_o}, 64'd0);
        exp_re.delete(); exp_im.delete(); exp_bin.delete();
        occ = 0;
        exp_ovf = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", valid_o, 1'b0);
        check("post_rst_ovf", overflow_o, 1'b0);
        ramp_with_latency();
        wait_drained();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
